// File: rtl/mem_stage_pkg.sv
// Shared widths, load-size encodings and bus layouts for the MEM stage.
// Field order in each struct is MSB first and matches the wire-level buses.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 205;
    localparam int MS_TO_WS_BUS_WD = 200;
    localparam int MS_FORWARD_WD   = 40;

    localparam logic [1:0] LD_B = 2'b00;
    localparam logic [1:0] LD_H = 2'b01;
    localparam logic [1:0] LD_W = 2'b10;

    localparam int EXCP_ALE = 6;

    // Exception and CSR fields travel unchanged from EX to WB.
    typedef struct packed {
        logic        excp;
        logic [15:0] excp_num;
        logic [31:0] err_addr;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } tail_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        ertn;
        logic [4:0]  dest;
        logic        gr_we;
        logic        res_from_csr;
        logic        res_from_mem;
        logic        mem_req;
        logic [1:0]  ld_size;
        logic        ld_unsigned;
        logic [31:0] alu_result;
        tail_t       tail;
    } es_to_ms_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        ertn;
        logic [4:0]  dest;
        logic        gr_we;
        logic        res_from_csr;
        logic [31:0] final_result;
        tail_t       tail;
    } ms_to_ws_t;

    typedef struct packed {
        logic        valid;
        logic        gr_we;
        logic [4:0]  dest;
        logic        data_pending;
        logic [31:0] result;
    } ms_forward_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data shifter/extender: selects byte/half/word at addr[1:0] and sign/zero extends.
// Purely combinational, no flow control.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    output logic [31:0] result
);

    logic [31:0] raw;

    always_comb begin
        raw    = rdata >> {addr, 3'b000};
        result = raw;
        case (ld_size)
            LD_B:    result = {{24{~ld_unsigned & raw[7]}}, raw[7:0]};
            LD_H:    result = {{16{~ld_unsigned & raw[15]}}, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: waits for data_sram responses, aligns load data, feeds WB; minimum 1 cycle residency.
// Stalls (ms_allowin=0) while a request's data is outstanding or WB withholds ws_allowin.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       es_mem_inflight,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       ws_ex,
    output logic                       ms_ex,
    output logic [MS_FORWARD_WD-1:0]   ms_forward
);

    es_to_ms_t   ms_q, ms_d;
    logic        ms_valid_q, ms_valid_d;
    logic        data_got_q, data_got_d;
    logic [31:0] data_buf_q, data_buf_d;
    logic [1:0]  discard_cnt_q, discard_cnt_d;

    logic        data_take;
    logic        data_got;
    logic        ms_ready_go;
    logic        data_pending;
    logic        discard_dec;
    logic [1:0]  discard_inc;
    logic [31:0] load_rdata;
    logic [31:0] load_result;
    logic [31:0] final_result;
    ms_to_ws_t   ws_out;
    ms_forward_t fwd_out;

    // Responses are owed to flushed requests first; only a clean counter lets data through.
    always_comb begin
        data_take    = data_sram_data_ok && (discard_cnt_q == 2'd0) && ms_valid_q
                       && ms_q.mem_req && !data_got_q;
        data_got     = data_got_q || data_take;
        ms_ready_go  = !ms_q.mem_req || ms_q.tail.excp || data_got;
        ms_allowin   = !ms_valid_q || (ms_ready_go && ws_allowin);
        ms_to_ws_valid = ms_valid_q && ms_ready_go && !ws_ex;
        ms_ex        = ms_valid_q && (ms_q.tail.excp || ms_q.ertn);
        data_pending = ms_valid_q && ms_q.res_from_mem && !ms_ready_go;
        load_rdata   = data_got_q ? data_buf_q : data_sram_rdata;
    end

    mem_stage_load_align u_load_align (
        .rdata       (load_rdata),
        .addr        (ms_q.alu_result[1:0]),
        .ld_size     (ms_q.ld_size),
        .ld_unsigned (ms_q.ld_unsigned),
        .result      (load_result)
    );

    always_comb begin
        final_result = ms_q.res_from_mem ? load_result : ms_q.alu_result;

        ws_out.pc           = ms_q.pc;
        ws_out.ertn         = ms_q.ertn;
        ws_out.dest         = ms_q.dest;
        ws_out.gr_we        = ms_q.gr_we;
        ws_out.res_from_csr = ms_q.res_from_csr;
        ws_out.final_result = final_result;
        ws_out.tail         = ms_q.tail;
        ms_to_ws_bus        = ws_out;

        fwd_out.valid        = ms_valid_q;
        fwd_out.gr_we        = ms_q.gr_we;
        fwd_out.dest         = ms_q.dest;
        fwd_out.data_pending = data_pending;
        fwd_out.result       = final_result;
        ms_forward           = fwd_out;
    end

    always_comb begin
        ms_d       = ms_q;
        ms_valid_d = ms_valid_q;
        data_got_d = data_got_q;
        data_buf_d = data_buf_q;

        if (data_take) begin
            data_got_d = 1'b1;
            data_buf_d = data_sram_rdata;
        end
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
            data_got_d = 1'b0;
        end
        if (es_to_ms_valid && ms_allowin) begin
            ms_d = es_to_ms_bus;
        end
        if (ws_ex) begin
            ms_valid_d = 1'b0;
            data_got_d = 1'b0;
        end

        // A flush orphans the current load's request (if still unanswered) and any EX request.
        discard_inc = 2'd0;
        if (ws_ex) begin
            discard_inc = {1'b0, ms_valid_q && ms_q.mem_req && !data_got_q && !data_sram_data_ok}
                        + {1'b0, es_mem_inflight};
        end
        discard_dec   = data_sram_data_ok && (discard_cnt_q != 2'd0);
        discard_cnt_d = discard_cnt_q + discard_inc - {1'b0, discard_dec};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q    <= 1'b0;
            data_got_q    <= 1'b0;
            discard_cnt_q <= 2'd0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            data_got_q    <= data_got_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    // Payload and data buffer are qualified by ms_valid_q/data_got_q, so they need no reset.
    always_ff @(posedge clk) begin
        ms_q       <= ms_d;
        data_buf_q <= data_buf_d;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load alignment, stalls, stores, ALE pass-through, flush discard, reset.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         es_to_ms_valid;
    logic [204:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [199:0] ms_to_ws_bus;
    logic         es_mem_inflight;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ws_ex;
    logic         ms_ex;
    logic [39:0]  ms_forward;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] ERR_ADDR  = 32'hCAFE_F00D;
    localparam logic [13:0] CSR_NUM   = 14'h01A5;
    localparam logic [31:0] CSR_WMASK = 32'h0F0F_0F0F;
    localparam logic [31:0] CSR_WDATA = 32'h1234_ABCD;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .es_mem_inflight   (es_mem_inflight),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_ex             (ws_ex),
        .ms_ex             (ms_ex),
        .ms_forward        (ms_forward)
    );

    function automatic logic [204:0] mk(input logic [31:0] pc, input logic [4:0] dest,
                                        input logic gr_we, input logic rfm, input logic mem_req,
                                        input logic [1:0] sz, input logic uns,
                                        input logic [31:0] alu, input logic excp,
                                        input logic [15:0] excp_num);
        return {pc, 1'b0, dest, gr_we, 1'b0, rfm, mem_req, sz, uns, alu,
                excp, excp_num, ERR_ADDR, 1'b1, CSR_NUM, CSR_WMASK, CSR_WDATA};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset             = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        es_mem_inflight   = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ws_ex             = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_allowin", 32'(ms_allowin), 32'd1);
        chk("rst_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("rst_ms_ex", 32'(ms_ex), 32'd0);
        chk("rst_fwd_valid", 32'(ms_forward[39]), 32'd0);

        // ld.b at ...3, data in entry cycle; ld.bu follows back-to-back
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_0000, 5'd5, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 1'b0, 16'h0);
        tick();
        es_to_ms_bus      = mk(32'h1C00_0004, 5'd6, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 32'h0000_1003, 1'b0, 16'h0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_1234;
        #1;
        chk("ldb_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("ldb_result", ms_to_ws_bus[159:128], 32'hFFFF_FF80);
        chk("ldb_pc", ms_to_ws_bus[199:168], 32'h1C00_0000);
        chk("ldb_fwd_result", ms_forward[31:0], 32'hFFFF_FF80);
        chk("ldb_fwd_dest", 32'(ms_forward[37:33]), 32'd5);
        chk("ldb_pending", 32'(ms_forward[32]), 32'd0);
        chk("ldb_allowin", 32'(ms_allowin), 32'd1);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk("ldbu_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("ldbu_result", ms_to_ws_bus[159:128], 32'h0000_0080);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("ldbu_gone", 32'(ms_to_ws_valid), 32'd0);
        chk("ldbu_gone_allowin", 32'(ms_allowin), 32'd1);

        // ld.h at ...2 with data 3 cycles late, then WB backpressure exercises the data buffer
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_0010, 5'd7, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 1'b0, 16'h0);
        tick();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ldh_wait_allowin", 32'(ms_allowin), 32'd0);
            chk("ldh_wait_pending", 32'(ms_forward[32]), 32'd1);
            chk("ldh_wait_valid", 32'(ms_to_ws_valid), 32'd0);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h7ABC_0000;
        ws_allowin        = 1'b0;
        #1;
        chk("ldh_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("ldh_result", ms_to_ws_bus[159:128], 32'h0000_7ABC);
        chk("ldh_pending_clr", 32'(ms_forward[32]), 32'd0);
        chk("ldh_wb_stall", 32'(ms_allowin), 32'd0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hFFFF_FFFF;
        ws_allowin        = 1'b1;
        #1;
        chk("ldh_buf_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("ldh_buf_result", ms_to_ws_bus[159:128], 32'h0000_7ABC);
        chk("ldh_buf_allowin", 32'(ms_allowin), 32'd1);
        tick();
        #1;
        chk("ldh_gone", 32'(ms_to_ws_valid), 32'd0);

        // store: data_ok in entry cycle, result is the address
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_0020, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_4444, 1'b0, 16'h0);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555_5555;
        #1;
        chk("st_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("st_result", ms_to_ws_bus[159:128], 32'h0000_4444);
        chk("st_gr_we", 32'(ms_to_ws_bus[161]), 32'd0);
        chk("st_allowin", 32'(ms_allowin), 32'd1);
        tick();
        data_sram_data_ok = 1'b0;

        // misaligned ld.h arrives as ALE with no request
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_0030, 5'd8, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_1001, 1'b1, 16'h0040);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk("ale_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("ale_ms_ex", 32'(ms_ex), 32'd1);
        chk("ale_excp", 32'(ms_to_ws_bus[127]), 32'd1);
        chk("ale_excp_num", 32'(ms_to_ws_bus[126:111]), 32'h0040);
        chk("ale_err_addr", ms_to_ws_bus[110:79], ERR_ADDR);
        chk("ale_csr_wdata", ms_to_ws_bus[31:0], CSR_WDATA);
        chk("ale_allowin", 32'(ms_allowin), 32'd1);
        tick();
        #1;
        chk("ale_gone_ms_ex", 32'(ms_ex), 32'd0);

        // flush with one load waiting and one EX request in flight: two responses dropped
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_0040, 5'd9, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_3000, 1'b0, 16'h0);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk("dis_wait_pending", 32'(ms_forward[32]), 32'd1);
        ws_ex           = 1'b1;
        es_mem_inflight = 1'b1;
        #1;
        chk("dis_flush_valid", 32'(ms_to_ws_valid), 32'd0);
        tick();
        ws_ex             = 1'b0;
        es_mem_inflight   = 1'b0;
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = mk(32'h1C00_0050, 5'd10, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_3004, 1'b0, 16'h0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAD0_0001;
        #1;
        chk("dis_flushed_allowin", 32'(ms_allowin), 32'd1);
        chk("dis_flushed_valid", 32'(ms_to_ws_valid), 32'd0);
        tick();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'hBAD0_0002;
        #1;
        chk("dis_stale2_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("dis_stale2_pending", 32'(ms_forward[32]), 32'd1);
        chk("dis_stale2_allowin", 32'(ms_allowin), 32'd0);
        tick();
        data_sram_rdata = 32'h1234_5678;
        #1;
        chk("dis_good_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("dis_good_result", ms_to_ws_bus[159:128], 32'h1234_5678);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("dis_good_gone", 32'(ms_to_ws_valid), 32'd0);

        // reset while a load waits
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_0060, 5'd11, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_5000, 1'b0, 16'h0);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk("rstw_allowin_before", 32'(ms_allowin), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rstw_allowin", 32'(ms_allowin), 32'd1);
        chk("rstw_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("rstw_fwd_valid", 32'(ms_forward[39]), 32'd0);

        // reset after a flush must also clear the pending discards
        es_to_ms_valid = 1'b1;
        tick();
        es_to_ms_valid  = 1'b0;
        ws_ex           = 1'b1;
        es_mem_inflight = 1'b1;
        tick();
        ws_ex           = 1'b0;
        es_mem_inflight = 1'b0;
        reset           = 1'b1;
        tick();
        reset          = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_0070, 5'd12, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_6000, 1'b0, 16'h0);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hA5A5_5A5A;
        #1;
        chk("rstd_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("rstd_result", ms_to_ws_bus[159:128], 32'hA5A5_5A5A);
        tick();
        data_sram_data_ok = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
